// File: rtl/multi_ring_allocator.sv
// multi_ring_allocator: per-channel ring allocator issuing {channel, offset} buffer addresses with credit tracking.
// Latency: alloc acked combinationally in cycle t, result valid from t+1; sustains one result per cycle.
// Backpressure: result held stable until linear_ack; a new alloc is acked only when the result slot frees. ALLOCATOR_FALSE_EN adds size-0 false alloc/free.
module multi_ring_allocator #(
    parameter int CH_LBW = 4,
    parameter int N_CH = 2,
    parameter int N_ICFG = 4,
    localparam int CH_BW = $clog2(N_CH),
    localparam int LBW = CH_LBW + CH_BW,
    localparam int ICFG_BW = $clog2(N_ICFG + 1),
    localparam int SW = CH_LBW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_ICFG*SW-1:0]  i_sizes,
    input  logic                  alloc_rdy,
    output logic                  alloc_ack,
    input  logic [ICFG_BW-1:0]    i_alloc_id,
    input  logic [CH_BW-1:0]      i_alloc_ch,
    output logic                  linear_rdy,
    input  logic                  linear_ack,
    output logic [LBW-1:0]        o_linear,
    output logic [ICFG_BW-1:0]    o_linear_id,
    output logic [CH_BW-1:0]      o_linear_ch,
    input  logic                  free_dval,
    input  logic [ICFG_BW-1:0]    i_free_id,
    input  logic [CH_BW-1:0]      i_free_ch,
    input  logic                  blkdone_dval,
    input  logic [CH_BW-1:0]      i_blkdone_ch,
`ifdef ALLOCATOR_FALSE_EN
    input  logic                  i_false_alloc,
    input  logic                  i_false_free,
    output logic                  o_false_alloc,
`endif
    output logic                  o_err
);

    localparam logic [SW-1:0] CAP_FULL = {1'b1, {CH_LBW{1'b0}}};

    logic [SW-1:0]     cap_q [N_CH];
    logic [SW-1:0]     cap_d [N_CH];
    logic [CH_LBW-1:0] cur_q [N_CH];
    logic [CH_LBW-1:0] cur_d [N_CH];
    logic [SW-1:0]     asize;
    logic [SW-1:0]     fsize;
    logic              slot_free;
    logic              err_set;

    // Ids beyond the table read as size 0 rather than X.
    function automatic logic [SW-1:0] size_of(input logic [N_ICFG*SW-1:0] tbl,
                                              input logic [ICFG_BW-1:0] id);
        size_of = '0;
        for (int k = 0; k < N_ICFG; k++)
            if (id == ICFG_BW'(k)) size_of = tbl[k*SW +: SW];
    endfunction

    always_comb begin
        asize = size_of(i_sizes, i_alloc_id);
        fsize = size_of(i_sizes, i_free_id);
`ifdef ALLOCATOR_FALSE_EN
        if (i_false_alloc) asize = '0;
        if (i_false_free)  fsize = '0;
`endif
    end

    assign slot_free = !linear_rdy || linear_ack;
    // Admission sees the registered cap only; a same-cycle free helps next cycle.
    assign alloc_ack = alloc_rdy && slot_free && (cap_q[i_alloc_ch] >= asize);

    always_comb begin
        logic [SW:0] sum;
        sum     = '0;
        err_set = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            sum = {1'b0, cap_q[c]};
            if (free_dval && i_free_ch == CH_BW'(c))
                sum = sum + {1'b0, fsize};
            if (alloc_ack && i_alloc_ch == CH_BW'(c))
                sum = sum - {1'b0, asize};
            if (sum > {1'b0, CAP_FULL}) begin
                cap_d[c] = CAP_FULL;
                err_set  = 1'b1;
            end else begin
                cap_d[c] = sum[SW-1:0];
            end
            cur_d[c] = cur_q[c];
            if (alloc_ack && i_alloc_ch == CH_BW'(c))
                cur_d[c] = cur_q[c] + asize[CH_LBW-1:0];
            if (blkdone_dval && i_blkdone_ch == CH_BW'(c))
                cur_d[c] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                cap_q[c] <= CAP_FULL;
                cur_q[c] <= '0;
            end
            linear_rdy    <= 1'b0;
            o_linear      <= '0;
            o_linear_id   <= '0;
            o_linear_ch   <= '0;
            o_err         <= 1'b0;
`ifdef ALLOCATOR_FALSE_EN
            o_false_alloc <= 1'b0;
`endif
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cap_q[c] <= cap_d[c];
                cur_q[c] <= cur_d[c];
            end
            if (err_set) o_err <= 1'b1;
            if (alloc_ack) begin
                linear_rdy    <= 1'b1;
                o_linear      <= {i_alloc_ch, cur_q[i_alloc_ch]};
                o_linear_id   <= i_alloc_id;
                o_linear_ch   <= i_alloc_ch;
`ifdef ALLOCATOR_FALSE_EN
                o_false_alloc <= i_false_alloc;
`endif
            end else if (linear_ack) begin
                linear_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_ring_allocator.sv
// Bench for multi_ring_allocator: CH_LBW=4, N_CH=2, sizes {id0:6, id1:0, id2:16, id3:4}.
module tb_multi_ring_allocator;

    typedef struct packed {
        logic [4:0] lin;
        logic [2:0] id;
        logic       fa;
    } exp_t;

    logic        clk;
    logic        i_rst;
    logic [19:0] i_sizes;
    logic        alloc_rdy, alloc_ack;
    logic [2:0]  i_alloc_id;
    logic        i_alloc_ch;
    logic        linear_rdy, linear_ack;
    logic [4:0]  o_linear;
    logic [2:0]  o_linear_id;
    logic        o_linear_ch;
    logic        free_dval;
    logic [2:0]  i_free_id;
    logic        i_free_ch;
    logic        blkdone_dval;
    logic        i_blkdone_ch;
    logic        o_err;
    logic        false_a;
    logic        false_f;
`ifdef ALLOCATOR_FALSE_EN
    logic        o_false_alloc;
`endif

    int   checks;
    int   errors;
    exp_t sb[$];

    multi_ring_allocator #(.CH_LBW(4), .N_CH(2), .N_ICFG(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sizes(i_sizes),
        .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
        .i_alloc_id(i_alloc_id), .i_alloc_ch(i_alloc_ch),
        .linear_rdy(linear_rdy), .linear_ack(linear_ack),
        .o_linear(o_linear), .o_linear_id(o_linear_id), .o_linear_ch(o_linear_ch),
        .free_dval(free_dval), .i_free_id(i_free_id), .i_free_ch(i_free_ch),
        .blkdone_dval(blkdone_dval), .i_blkdone_ch(i_blkdone_ch),
`ifdef ALLOCATOR_FALSE_EN
        .i_false_alloc(false_a), .i_false_free(false_f), .o_false_alloc(o_false_alloc),
`endif
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_pulses();
        alloc_rdy    = 1'b0;
        free_dval    = 1'b0;
        blkdone_dval = 1'b0;
    endtask

    // Scoreboard drain: a result handshakes on the coming edge when rdy && ack.
    task automatic at_neg();
        exp_t e;
        logic bad;
        @(negedge clk);
        if (linear_rdy && linear_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got lin=%0h id=%0d", o_linear, o_linear_id);
            end else begin
                e = sb.pop_front();
                bad = (o_linear !== e.lin) || (o_linear_id !== e.id) || (o_linear_ch !== e.lin[4]);
`ifdef ALLOCATOR_FALSE_EN
                bad = bad || (o_false_alloc !== e.fa);
`endif
                if (bad) begin
                    errors++;
                    $display("FAIL result got lin=%0h id=%0d ch=%0b want lin=%0h id=%0d",
                             o_linear, o_linear_id, o_linear_ch, e.lin, e.id);
                end
            end
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic idle_step();
        at_neg();
        to_next();
    endtask

    task automatic alloc_step(input logic ch, input logic [2:0] id, input bit exp_ack,
                              input logic [3:0] exp_off, input string name);
        alloc_rdy  = 1'b1;
        i_alloc_ch = ch;
        i_alloc_id = id;
        at_neg();
        checks++;
        if (alloc_ack !== exp_ack) begin
            errors++;
            $display("FAIL %s alloc_ack got %0b want %0b", name, alloc_ack, exp_ack);
        end
        if (exp_ack) sb.push_back('{lin: {ch, exp_off}, id: id, fa: false_a});
        to_next();
    endtask

    task automatic do_free(input logic ch, input logic [2:0] id);
        free_dval = 1'b1;
        i_free_ch = ch;
        i_free_id = id;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        clear_pulses();
        false_a = 1'b0;
        false_f = 1'b0;
        sb.delete();
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string name);
        alloc_rdy  = 1'b0;
        linear_ack = 1'b1;
        idle_step();
        idle_step();
        checks++;
        if (sb.size() != 0 || linear_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain left %0d results, linear_rdy %0b want 0/0", name, sb.size(), linear_rdy);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (linear_rdy !== 1'b0 || o_linear !== 5'd0 || o_linear_id !== 3'd0 ||
            o_linear_ch !== 1'b0 || o_err !== 1'b0 || alloc_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%0b lin=%0h id=%0d ch=%0b err=%0b ack=%0b want all 0",
                     linear_rdy, o_linear, o_linear_id, o_linear_ch, o_err, alloc_ack);
        end
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        linear_ack = 1'b1;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0,  "b2b_first");
        alloc_step(1'b0, 3'd0, 1'b1, 4'd6,  "b2b_second");
        alloc_step(1'b0, 3'd0, 1'b0, 4'd0,  "b2b_cap_stall");
        do_free(1'b0, 3'd0);
        alloc_step(1'b0, 3'd0, 1'b0, 4'd0,  "b2b_no_free_bypass");
        alloc_step(1'b0, 3'd0, 1'b1, 4'd12, "b2b_after_free");
    endtask

    task automatic test_wrap();
        do_free(1'b0, 3'd0);
        idle_step();
        alloc_step(1'b0, 3'd0, 1'b1, 4'd2, "wrap_cursor");
        drain_check("wrap");
    endtask

    task automatic test_same_cycle_free();
        do_reset();
        linear_ack = 1'b1;
        alloc_step(1'b1, 3'd2, 1'b1, 4'd0, "same_fill16");
        do_free(1'b1, 3'd0);
        alloc_step(1'b1, 3'd0, 1'b0, 4'd0, "same_cycle_blocked");
        alloc_step(1'b1, 3'd0, 1'b1, 4'd0, "same_next_acked");
        alloc_step(1'b1, 3'd3, 1'b0, 4'd0, "same_cap_zero");
        alloc_step(1'b1, 3'd1, 1'b1, 4'd6, "size_zero_acked");
        drain_check("same");
    endtask

    task automatic test_blkdone();
        do_reset();
        linear_ack = 1'b1;
        alloc_step(1'b1, 3'd3, 1'b1, 4'd0, "blk_ch1_first");
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0, "blk_ch0_first");
        blkdone_dval = 1'b1;
        i_blkdone_ch = 1'b0;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd6, "blk_concurrent_ack");
        alloc_step(1'b0, 3'd3, 1'b1, 4'd0, "blk_cursor_reset");
        alloc_step(1'b1, 3'd3, 1'b1, 4'd4, "blk_ch1_untouched");
        drain_check("blk");
    endtask

    task automatic test_overfree();
        do_reset();
        linear_ack = 1'b1;
        do_free(1'b0, 3'd0);
        at_neg();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL overfree_err_early got %0b want 0", o_err);
        end
        to_next();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL overfree_err_set got %0b want 1", o_err);
        end
        alloc_step(1'b0, 3'd2, 1'b1, 4'd0, "overfree_cap_full");
        alloc_step(1'b0, 3'd3, 1'b0, 4'd0, "overfree_cap_saturated");
        idle_step();
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL overfree_err_sticky got %0b want 1", o_err);
        end
        do_reset();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL overfree_err_cleared got %0b want 0", o_err);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        linear_ack = 1'b0;
        alloc_step(1'b0, 3'd3, 1'b1, 4'd0, "bp_first");
        alloc_step(1'b1, 3'd3, 1'b0, 4'd0, "bp_slot_busy");
        checks++;
        if (linear_rdy !== 1'b1 || o_linear !== 5'h00 || o_linear_id !== 3'd3) begin
            errors++;
            $display("FAIL bp_hold rdy=%0b lin=%0h id=%0d want 1/00/3", linear_rdy, o_linear, o_linear_id);
        end
        linear_ack = 1'b1;
        alloc_step(1'b1, 3'd3, 1'b1, 4'd0, "bp_ack_same_cycle");
        checks++;
        if (linear_rdy !== 1'b1 || o_linear !== 5'h10) begin
            errors++;
            $display("FAIL bp_sustain rdy=%0b lin=%0h want 1/10", linear_rdy, o_linear);
        end
        idle_step();
        checks++;
        if (linear_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop got %0b want 0", linear_rdy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_scoreboard left %0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        linear_ack = 1'b0;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0, "mid_alloc");
        do_reset();
        checks++;
        if (linear_rdy !== 1'b0 || o_linear !== 5'd0 || o_linear_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_drop rdy=%0b lin=%0h id=%0d want 0/0/0", linear_rdy, o_linear, o_linear_id);
        end
        linear_ack = 1'b1;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0, "mid_after_reset");
        drain_check("mid");
    endtask

`ifdef ALLOCATOR_FALSE_EN
    task automatic test_false_alloc();
        do_reset();
        linear_ack = 1'b1;
        false_a = 1'b1;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0, "false_acked");
        false_a = 1'b0;
        alloc_step(1'b0, 3'd0, 1'b1, 4'd0, "false_cur_unchanged");
        alloc_step(1'b0, 3'd0, 1'b1, 4'd6, "false_cap_unchanged");
        false_f = 1'b1;
        do_free(1'b0, 3'd0);
        idle_step();
        false_f = 1'b0;
        alloc_step(1'b0, 3'd0, 1'b0, 4'd0, "false_free_no_credit");
        drain_check("false");
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        i_rst        = 1'b0;
        i_sizes      = {5'd4, 5'd16, 5'd0, 5'd6};
        linear_ack   = 1'b0;
        i_alloc_id   = 3'd0;
        i_alloc_ch   = 1'b0;
        i_free_id    = 3'd0;
        i_free_ch    = 1'b0;
        i_blkdone_ch = 1'b0;
        false_a      = 1'b0;
        false_f      = 1'b0;
        clear_pulses();

        test_reset();
        test_back_to_back();
        test_wrap();
        test_same_cycle_free();
        test_blkdone();
        test_overfree();
        test_backpressure();
        test_reset_mid_txn();
`ifdef ALLOCATOR_FALSE_EN
        test_false_alloc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
